// File: rtl/result_tx_pkg.sv
// rtl/result_tx_pkg.sv - shared types and sizing for the result transmit framer
// Optional feature macro: RESULT_TX_CHECKSUM_EN
package result_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_DONE
  } state_t;

  localparam int NB_BYTE = 8;

  // Bytes per frame: the result bytes, plus the trailing XOR byte when enabled
  function automatic int byte_count(input int nb_out);
`ifdef RESULT_TX_CHECKSUM_EN
    return (nb_out / NB_BYTE) + 1;
`else
    return nb_out / NB_BYTE;
`endif
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// rtl/tx_watchdog.sv - per-byte watchdog that flags a silent transmitter
module tx_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count enabled cycles, saturating at the limit so the flag cannot wrap
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_enable && (cnt_q == LIMIT);

endmodule

// File: rtl/result_tx_framer.sv
// rtl/result_tx_framer.sv - serialises a latched ALU result into UART bytes, LSB byte first
// Optional feature macro: RESULT_TX_CHECKSUM_EN (adds trailing XOR byte)
module result_tx_framer
  import result_tx_pkg::*;
#(
  parameter int NB_OUT         = 16,
  parameter int NB_BYTE        = result_tx_pkg::NB_BYTE,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_OUT-1:0]  i_result,
  input  logic               i_result_valid,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overrun,
  output logic               o_timeout
);

  localparam int N_BYTES = byte_count(NB_OUT);
  localparam int SHIFT_W = N_BYTES * NB_BYTE;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t             state_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] load_d;
  logic [IDX_W-1:0]   idx_q;
  logic               start_q;
  logic [NB_BYTE-1:0] tx_data_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               overrun_q;
  logic               timeout_q;
  logic               wd_expired;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum;

  // Fold the result bytes into one XOR byte, carried as the last byte of the frame
  always_comb begin
    csum = '0;
    for (int k = 0; k < NB_OUT / NB_BYTE; k++) begin
      csum = csum ^ i_result[k*NB_BYTE +: NB_BYTE];
    end
    load_d = {csum, i_result};
  end
`else
  assign load_d = i_result;
`endif

  // Watchdog only runs while waiting for a byte; any other state holds it at zero
  tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (state_q != WAIT_DONE),
    .i_enable (state_q == WAIT_DONE),
    .o_expired(wd_expired)
  );

  // Frame FSM with registered pulse outputs; the low byte of the shift register is always next
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      start_q      <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      if (i_result_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_result_valid) begin
            shift_q <= load_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          if (!i_tx_busy) begin
            start_q   <= 1'b1;
            tx_data_q <= shift_q[NB_BYTE-1:0];
            state_q   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_q >> NB_BYTE;
              state_q <= ARM;
            end
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start   = start_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule

// File: doc/result_tx_framer.md
# result_tx_framer

Downstream stage between the ALU and the UART transmitter. Captures a full NB_OUT-bit ALU result on a valid pulse and serialises it into consecutive bytes, LSB byte first, issuing one transmitter start per byte and waiting for each byte's completion. This makes the whole result visible on the serial line, not only its low byte. A watchdog aborts the frame if the transmitter stops responding.

## Interface
- NB_OUT, 16: result width; must be a multiple of 8, minimum 8.
- NB_BYTE, 8: transmitter data width.
- TIMEOUT_CYCLES, 100000: maximum clock cycles to wait for i_tx_done per byte, which covers one 10-bit frame at 9600 bd on 50 MHz. Must be greater than 0.
- i_clk, in, 1: the block's only clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_result, in, NB_OUT: ALU result, sampled only when i_result_valid=1 in IDLE.
- i_result_valid, in, 1: one-cycle pulse from the interface stage marking the result as valid.
- i_tx_busy, in, 1: transmitter is currently sending.
- i_tx_done, in, 1: one-cycle pulse marking the end of a byte's stop bit.
- o_tx_start, out, 1: one-cycle start pulse to the transmitter.
- o_tx_data, out, NB_BYTE: byte to send; stable from the o_tx_start cycle until the next start or return to IDLE.
- o_busy, out, 1: frame in progress, high whenever state≠IDLE.
- o_frame_done, out, 1: one-cycle pulse after the last byte's i_tx_done.
- o_overrun, out, 1: one-cycle pulse when i_result_valid arrives while o_busy=1; that result is dropped.
- o_timeout, out, 1: one-cycle pulse when the watchdog aborts a frame.

## Operation
- Byte count per frame: N = NB_OUT/8, plus 1 when checksum is enabled.
- IDLE: on i_result_valid, latch i_result into the shift register, clear the byte index and go to ARM.
- ARM: while i_tx_busy=1, stay. Otherwise, pulse o_tx_start with o_tx_data = the current byte, clear the watchdog and go to WAIT_DONE.
- WAIT_DONE: on i_tx_done:
  - if this was the last byte, pulse o_frame_done and go to IDLE;
  - else increment the byte index and go to ARM.
- Watchdog in WAIT_DONE: if the counter reaches TIMEOUT_CYCLES-1 without i_tx_done, pulse o_timeout and go to IDLE. No o_frame_done is issued.
- Byte order: byte k = i_result[8k+7:8k], k=0..N-1.
- If i_tx_done and the watchdog limit occur in the same cycle, i_tx_done wins.
- i_tx_done seen in IDLE or ARM is ignored.
- i_result_valid in any state other than IDLE gives o_overrun, and latched data is unaffected.
- In IDLE, a valid pulse starts a frame normally; no overrun.

## Timing
- Reset values:
  - state = IDLE;
  - o_tx_start, o_busy, o_frame_done, o_overrun, o_timeout = 0;
  - o_tx_data = 0;
  - watchdog and byte index = 0.
- Reset mid-frame: on the next edge all outputs return to their reset values and the frame is abandoned.
- Latency, valid to first o_tx_start: 2 cycles when i_tx_busy=0 (IDLE→ARM, ARM→start). Each extra busy cycle adds 1.
- Inter-byte gap after i_tx_done: 1 cycle in ARM plus any busy cycles.
- o_busy rises the cycle after i_result_valid and falls in the same cycle as the o_frame_done or o_timeout pulse.

## Configuration
- RESULT_TX_CHECKSUM_EN defined: one extra trailing byte equal to the XOR of all N result bytes is sent. o_frame_done follows that byte.
- Not defined: exactly NB_OUT/8 bytes are sent, and no checksum logic is present.

## Structure
- Package result_tx_pkg holds:
  - state enum {IDLE, ARM, WAIT_DONE};
  - NB_BYTE constant;
  - byte-count function of NB_OUT and the macro.
- Sub-module tx_watchdog holds the timeout counter. Inputs: clear and enable. Output: expired pulse. Parameter: TIMEOUT_CYCLES.

## Test plan
- i_result=0xA55A, transmitter model done 20 cycles after start → o_tx_data 0x5A then 0xA5, o_frame_done after the 2nd done. With checksum on, a third byte 0xFF.
- i_tx_busy held 1 for 5 cycles at valid → first o_tx_start 7 cycles after valid, data 0x34 for i_result=0x1234.
- Second valid during frame → o_overrun pulse, transmitted bytes are still those of the first result.
- TIMEOUT_CYCLES=10, never send done → o_timeout exactly 10 cycles after o_tx_start, o_busy=0 in the same cycle, no o_frame_done.
- i_reset asserted in WAIT_DONE of byte 1 → next cycle all outputs 0. A later valid with 0x00FF sends 0xFF, 0x00.
- NB_OUT=8, i_result=0x3C → single start with 0x3C, then done. With checksum on, second byte 0x3C.
